// File: rtl/prefix_seq_divider_if.sv
// Operand/result valid-ready bundle for prefix_seq_divider.
// The divider takes the slave modport and its requester takes the master modport.
interface prefix_seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/prefix_seq_divider.sv
// Multi-cycle non-restoring unsigned divider producing one quotient bit per cycle.
// Optional feature macro: DIV_ABORT_EN adds an abort input that cancels RUN/FIX.
module prefix_seq_divider #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
`ifdef DIV_ABORT_EN
  input logic abort,
`endif
  prefix_seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             abort_s;
  logic [WIDTH:0]   r_sh_s;
  logic [WIDTH:0]   d_ext_s;
  logic [WIDTH:0]   r_step_s;
  logic [WIDTH-1:0] rem_fix_s;

`ifdef DIV_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // One non-restoring step: the sign of the partial remainder picks add or subtract.
  always_comb begin
    r_sh_s  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    d_ext_s = {1'b0, d_q};
    if (r_q[WIDTH] == 1'b0) begin
      r_step_s = r_sh_s + ~d_ext_s + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      r_step_s = r_sh_s + d_ext_s;
    end
  end

  // Final correction; the corrected remainder lies in [0, D), so the low bits are exact.
  always_comb begin
    if (r_q[WIDTH] == 1'b1) begin
      rem_fix_s = r_q[WIDTH-1:0] + d_q;
    end else begin
      rem_fix_s = r_q[WIDTH-1:0];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid == 1'b1) begin
          if (bus.divisor == {WIDTH{1'b0}}) begin
            state_d = DONE;
            quo_d   = {WIDTH{1'b1}};
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            r_d     = {(WIDTH+1){1'b0}};
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_s == 1'b1) begin
          state_d = IDLE;
        end else begin
          r_d   = r_step_s;
          q_d   = {q_q[WIDTH-2:0], ~r_step_s[WIDTH]};
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_STEP) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
      end
      FIX: begin
        if (abort_s == 1'b1) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          quo_d   = q_q;
          rem_d   = rem_fix_s;
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready == 1'b1) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= {(WIDTH+1){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_prefix_seq_divider.sv
// Scoreboard bench for prefix_seq_divider: the driver pushes expected results computed
// with plain / and %, and a monitor pops and compares them whenever a result is presented.
module tb_prefix_seq_divider;
  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               acc;
    int               lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef DIV_ABORT_EN
  logic abort = 1'b0;
`endif
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   bp_force = 1'b0;
  bit   mon_seen = 1'b0;
  exp_t sb[$];

  prefix_seq_divider_if #(.WIDTH(WIDTH)) bus ();

  prefix_seq_divider #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef DIV_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int acc);
    exp_t e;
    if (b == 0) begin
      e.q = {WIDTH{1'b1}}; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = WIDTH + 2;
    end
    e.acc = acc;
    return e;
  endfunction

  // Called one time unit after a rising edge; returns at the same phase after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int g = 0;
    while (bus.in_ready !== 1'b1 && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 200) begin
      fail_now("accept_timeout");
      return;
    end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(a, b, cyc));
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || bus.in_ready !== 1'b1) && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 500) fail_now("drain_timeout");
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on first presentation, stability while held, values on transfer.
  initial begin
    logic [WIDTH-1:0] hq, hr;
    logic             hd;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_seen = 1'b0;
      end else if (bus.out_valid === 1'b1) begin
        if (!mon_seen) begin
          mon_seen = 1'b1;
          hq = bus.quotient; hr = bus.remainder; hd = bus.div_by_zero;
          if (sb.size() == 0) fail_now("unexpected_result");
          else check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
        end else begin
          check("hold_quotient", 32'(bus.quotient), 32'(hq));
          check("hold_remainder", 32'(bus.remainder), 32'(hr));
          check("hold_div_by_zero", 32'(bus.div_by_zero), 32'(hd));
        end
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready === 1'b1) begin
          if (sb.size() != 0) begin
            check("quotient", 32'(bus.quotient), 32'(sb[0].q));
            check("remainder", 32'(bus.remainder), 32'(sb[0].r));
            check("div_by_zero", 32'(bus.div_by_zero), 32'(sb[0].dbz));
            void'(sb.pop_front());
          end
          mon_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    int g;
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_quotient", 32'(bus.quotient), 32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(16'd100, 16'd7);
    issue(16'hFFFF, 16'h0001);
    issue(16'h1234, 16'hFFFF);
    issue(16'd5, 16'd0);
    issue(16'd9, 16'd3);
    issue(16'd0, 16'd17);
    drain();

    // Backpressure with an ignored in_valid pulse during RUN.
    bp_force = 1'b1;
    issue(16'd1000, 16'd7);
    repeat (3) begin @(posedge clk); #1; end
    bus.dividend = 16'd77; bus.divisor = 16'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    g = 0;
    while (bus.out_valid !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
    if (g >= 100) fail_now("bp_wait_valid");
    repeat (5) begin @(posedge clk); #1; end
    bp_force = 1'b0;
    drain();

    // Reset in the middle of a divide.
    issue(16'd40000, 16'd123);
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    check("midrst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(16'd50, 16'd6);
    drain();

`ifdef DIV_ABORT_EN
    issue(16'd60000, 16'd7);
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    void'(sb.pop_back());
    repeat (25) @(posedge clk);
    #1;
    issue(16'd1000, 16'd33);
    drain();
`endif

    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = (a == {WIDTH{1'b1}}) ? WIDTH'(1) : WIDTH'(int'(a) + int'($urandom_range(1, 65535 - int'(a))));
        2: begin a = '0; b = WIDTH'($urandom_range(1, 65535)); end
        3: b = WIDTH'($urandom_range(1, 15));
        default: b = WIDTH'($urandom);
      endcase
      issue(a, b);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
